insdec_pipe: RTL and testbench
==============================

// Module: insdec_pipe
// PURPOSE
// - Parametrised, registered successor of the combinational instruction-field splitter for the multi-cycle CPU.
// - Sits between fetch and the control FSM, with valid/ready on both sides and a 2-entry skid buffer.
// - Splits fields, builds an extended immediate and classifies the opcode.
// - Holds a HALT state, entered on the all-ones opcode and left on a resume pulse.
// PARAMETERS
// - OPW  5   opcode field width
// - AMW  2   addressing-mode field width (AMW >= 2)
// - RW   3   register-index field width (dst, src1, src2 each)
// - DW   16  data/immediate output width (DW >= 2*RW)
// - NOPS 20  opcodes 0..NOPS-1 are legal; all-ones is HALT; all others are illegal
// - Derived localparam IW = OPW+AMW+3*RW (16 at defaults)
// PORTS
// - clk        in   1    rising-edge clock
// - rst_n      in   1    synchronous, active-low reset
// - in_valid   in   1    fetch presents an instruction
// - in_ready   out  1    decoder can accept; registered
// - in_ins     in   IW   {op, am, dst, src1, src2}, MSB first
// - out_valid  out  1    decoded bundle valid
// - out_ready  in   1    control FSM consumes the bundle
// - op_code    out  OPW  opcode field
// - addr_mode  out  AMW  addressing-mode field
// - dst, src1, src2  out  RW each  register fields
// - imm        out  DW   immediate; extended {src1,src2}
// - is_illegal out  1    opcode is neither legal nor HALT
// - is_halt    out  1    opcode is HALT
// - halted     out  1    decoder is in the HALT state
// - resume     in   1    one-cycle pulse that leaves HALT
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge): every output is driven to 0, except in_ready, which is 1 once reset is released.
//   - Both buffer entries are emptied; the FSM returns to RUN.
//   - Reset overrides any in-flight handshake; buffered instructions are discarded.
// - Transfers: an input transfer occurs when in_valid & in_ready; an output transfer when out_valid & out_ready.
// - Latency: one cycle from input transfer to out_valid. Throughput is 1/clk while out_ready stays high.
// - Output stability: while out_valid & !out_ready, every out_* field holds stable.
// - Skid buffer: the output register plus one skid register.
//   - in_ready is registered and equals !skid_full.
//   - An input transfer that arrives while the output is stalled goes into skid.
//   - On the next output transfer, skid moves into the output register.
//   - Ordering is strictly FIFO.
// - Full condition (output and skid both occupied): in_ready=0.
//   - A simultaneous output transfer and input transfer is legal when skid is empty.
//   - In that case the new instruction goes straight to the output register.
// - Immediate extension:
//   - am==01: imm = sign-extend {src1,src2} to DW.
//   - All other modes: imm = zero-extend {src1,src2} to DW.
// - FSM, two states:
//   - RUN: accepts input.
//   - HALT: in_ready=0 and halted=1; entered the cycle after a HALT instruction makes its output transfer.
//   - HALT -> RUN: on resume=1; in_ready rises the following cycle.
// - Simultaneous events:
//   - resume in RUN is ignored.
//   - Instructions accepted before HALT still drain in order.
//   - Buffered entries behind a HALT cannot exist, because HALT is detected at input and in_ready drops after its input transfer.
// - is_illegal passes downstream as a flag only; it has no FSM effect unless the trap feature below is enabled.
// CONFIGURATION
// - Macro INSDEC_ILLEGAL_TRAP_EN.
// - Defined:
//   - Adds a third FSM state, TRAP, and an output port trap (1 bit, reset 0).
//   - An illegal opcode's output transfer enters TRAP: in_ready=0, trap=1.
//   - Only resume or reset returns the FSM to RUN.
// - Undefined: no trap port and no TRAP state; illegal opcodes flow through flagged.
// STRUCTURE
// - Package insdec_pkg holds:
//   - field-width defaults;
//   - the AM_REG=00, AM_IMM=01, AM_DIR=10, AM_IND=11 constants;
//   - the FSM state enum;
//   - a packed struct for the decoded bundle;
//   - the function classify(op) -> {illegal, halt}.
// - One sub-module, insdec_skid: a generic 2-entry valid/ready skid buffer carrying the packed struct.
// - Field split and classification are combinational ahead of insdec_skid.
// TESTING
// - Reset: hold rst_n=0 for 3 clks with in_valid=1 -> out_valid=0, imm=0, halted=0; in_ready=1 on the first clk after release.
// - Streaming: out_ready=1, back-to-back ins 16'h0A5F, 16'h1234 -> outputs on consecutive cycles.
//   - For 16'h0A5F: op=1, am=01, dst=1, src1=3, src2=7; imm=16'h001F (sign bit of {3,7}=011111 is 0).
//   - For am=01 with {src1,src2}=6'b111000, imm=16'hFFF8.
// - Backpressure: out_ready=0 while 3 ins are offered -> 2 accepted, in_ready=0.
//   - Releasing out_ready yields them in order; the third is accepted after the first output transfer.
// - Halt: send op=5'h1F then op=2 -> HALT bundle out, halted=1, op=2 not accepted.
//   - resume pulse -> in_ready=1 the next cycle; op=2 then flows.
// - Illegal: op=5'h15 (>=NOPS) -> is_illegal=1, is_halt=0.
//   - With INSDEC_ILLEGAL_TRAP_EN: trap=1 and in_ready=0 until resume.
// - Reset mid-operation: assert rst_n=0 while skid is full -> both entries dropped; no stale out_valid after release.

Source files
------------

// File: rtl/insdec_pkg.sv
// Shared definitions for the registered instruction decoder: field-width
// defaults, addressing-mode codes, FSM state encoding, the decoded bundle
// layout at default widths and the opcode classifier.
// Optional feature macro: INSDEC_ILLEGAL_TRAP_EN (adds the TRAP state).
package insdec_pkg;

  localparam int OPW_DEF  = 5;
  localparam int AMW_DEF  = 2;
  localparam int RW_DEF   = 3;
  localparam int DW_DEF   = 16;
  localparam int NOPS_DEF = 20;

  localparam logic [1:0] AM_REG = 2'b00;
  localparam logic [1:0] AM_IMM = 2'b01;
  localparam logic [1:0] AM_DIR = 2'b10;
  localparam logic [1:0] AM_IND = 2'b11;

`ifdef INSDEC_ILLEGAL_TRAP_EN
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_TRAP = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1
  } state_e;
`endif

  // Decoded bundle at default widths; the top rebuilds the same layout
  // from its own parameters.
  typedef struct packed {
    logic [OPW_DEF-1:0] op;
    logic [AMW_DEF-1:0] am;
    logic [RW_DEF-1:0]  dst;
    logic [RW_DEF-1:0]  src1;
    logic [RW_DEF-1:0]  src2;
    logic [DW_DEF-1:0]  imm;
    logic               is_illegal;
    logic               is_halt;
  } decoded_t;

  // Returns {illegal, halt}. HALT is the all-ones opcode; anything else at
  // or above nops is illegal.
  function automatic logic [1:0] classify(input logic [31:0] op,
                                          input int          opw,
                                          input int          nops);
    logic [31:0] all_ones;
    logic        halt;
    logic        illegal;
    all_ones = (32'd1 << opw) - 32'd1;
    halt     = (op == all_ones);
    illegal  = !halt && (op >= 32'(nops));
    return {illegal, halt};
  endfunction

endpackage

// File: rtl/insdec_skid.sv
// Generic 2-entry valid/ready skid buffer: an output register plus one skid
// register, strictly FIFO. in_ready is a flop equal to !skid_full, further
// forced low for the next cycle whenever block_d is set by the owner.
// Handshake: a transfer happens on a side only in a cycle where both valid
// and ready are high; the producer must hold data stable while valid & !ready.
module insdec_skid #(
  parameter type T = logic [0:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data,
  input  logic block_d
);

  logic out_vld_q, out_vld_d;
  logic skid_vld_q, skid_vld_d;
  logic ready_q, ready_d;
  T     out_data_q, out_data_d;
  T     skid_data_q, skid_data_d;
  logic push, pop;

  // Next-state of the two entries; skid refills the output on each pop.
  always_comb begin
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    push        = in_valid & ready_q;
    pop         = out_vld_q & out_ready;
    if (pop) begin
      if (skid_vld_q) begin
        out_data_d = skid_data_q;
        skid_vld_d = 1'b0;
      end else if (push) begin
        out_data_d = in_data;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (push) begin
      if (!out_vld_q) begin
        out_vld_d  = 1'b1;
        out_data_d = in_data;
      end else begin
        skid_vld_d  = 1'b1;
        skid_data_d = in_data;
      end
    end
    ready_d = !skid_vld_d && !block_d;
  end

  // Entry registers; reset empties both and holds in_ready low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld_q   <= 1'b0;
      skid_vld_q  <= 1'b0;
      ready_q     <= 1'b0;
      out_data_q  <= '0;
      skid_data_q <= '0;
    end else begin
      out_vld_q   <= out_vld_d;
      skid_vld_q  <= skid_vld_d;
      ready_q     <= ready_d;
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = out_vld_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/insdec_pipe.sv
// Registered instruction decoder between fetch and the control FSM. Splits
// {op, am, dst, src1, src2}, builds the extended immediate, classifies the
// opcode, and parks in HALT after a HALT instruction leaves the output.
// Optional feature macro: INSDEC_ILLEGAL_TRAP_EN (TRAP state + trap port).
module insdec_pipe
  import insdec_pkg::*;
#(
  parameter int OPW  = OPW_DEF,
  parameter int AMW  = AMW_DEF,
  parameter int RW   = RW_DEF,
  parameter int DW   = DW_DEF,
  parameter int NOPS = NOPS_DEF,
  localparam int IW  = OPW + AMW + 3 * RW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IW-1:0]  in_ins,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW-1:0] op_code,
  output logic [AMW-1:0] addr_mode,
  output logic [RW-1:0]  dst,
  output logic [RW-1:0]  src1,
  output logic [RW-1:0]  src2,
  output logic [DW-1:0]  imm,
  output logic           is_illegal,
  output logic           is_halt,
  output logic           halted,
`ifdef INSDEC_ILLEGAL_TRAP_EN
  output logic           trap,
`endif
  input  logic           resume
);

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [AMW-1:0] am;
    logic [RW-1:0]  dst;
    logic [RW-1:0]  src1;
    logic [RW-1:0]  src2;
    logic [DW-1:0]  imm;
    logic           is_illegal;
    logic           is_halt;
  } bundle_t;

  bundle_t          dec;
  bundle_t          out_b;
  logic [2*RW-1:0]  imm_raw;
  logic [1:0]       cls;
  logic             push, pop;
  logic             skid_in_ready, skid_out_valid;
  logic             block_d;
  logic             stop_in, stop_out;
  state_e           state_q, state_d;
  logic             pend_q, pend_d;

  // Field split, immediate extension and classification ahead of the buffer.
  always_comb begin
    dec      = '0;
    dec.op   = in_ins[IW-1 -: OPW];
    dec.am   = in_ins[3*RW +: AMW];
    dec.dst  = in_ins[2*RW +: RW];
    dec.src1 = in_ins[RW +: RW];
    dec.src2 = in_ins[0 +: RW];
    imm_raw  = {dec.src1, dec.src2};
    if (dec.am == AMW'(AM_IMM)) dec.imm = DW'($signed(imm_raw));
    else                        dec.imm = DW'(imm_raw);
    cls            = classify(32'(dec.op), OPW, NOPS);
    dec.is_illegal = cls[1];
    dec.is_halt    = cls[0];
  end

  assign push = in_valid & skid_in_ready;
  assign pop  = skid_out_valid & out_ready;

  // Instructions that stop the decoder, seen at input and at output.
`ifdef INSDEC_ILLEGAL_TRAP_EN
  assign stop_in  = dec.is_halt | dec.is_illegal;
  assign stop_out = out_b.is_halt | out_b.is_illegal;
`else
  assign stop_in  = dec.is_halt;
  assign stop_out = out_b.is_halt;
`endif

  // Run/halt FSM; pend covers a stopping instruction still in the buffer,
  // so nothing can be accepted behind it.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    if (push && stop_in) pend_d = 1'b1;
    if (pop && stop_out) pend_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (pop && out_b.is_halt) state_d = ST_HALT;
`ifdef INSDEC_ILLEGAL_TRAP_EN
        else if (pop && out_b.is_illegal) state_d = ST_TRAP;
`endif
      end
      ST_HALT: if (resume) state_d = ST_RUN;
`ifdef INSDEC_ILLEGAL_TRAP_EN
      ST_TRAP: if (resume) state_d = ST_RUN;
`endif
      default: state_d = ST_RUN;
    endcase
    block_d = (state_d != ST_RUN) || pend_d;
  end

  // FSM state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  insdec_skid #(.T(bundle_t)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (skid_in_ready),
    .in_data   (dec),
    .out_valid (skid_out_valid),
    .out_ready (out_ready),
    .out_data  (out_b),
    .block_d   (block_d)
  );

  assign in_ready   = skid_in_ready;
  assign out_valid  = skid_out_valid;
  assign op_code    = out_b.op;
  assign addr_mode  = out_b.am;
  assign dst        = out_b.dst;
  assign src1       = out_b.src1;
  assign src2       = out_b.src2;
  assign imm        = out_b.imm;
  assign is_illegal = out_b.is_illegal;
  assign is_halt    = out_b.is_halt;
  assign halted     = (state_q == ST_HALT);
`ifdef INSDEC_ILLEGAL_TRAP_EN
  assign trap       = (state_q == ST_TRAP);
`endif

endmodule

// File: tb/tb_insdec_pipe.sv
// Directed bench for insdec_pipe: reset, streaming, immediate extension,
// backpressure, HALT/resume, illegal opcode and reset with a full buffer.
module tb_insdec_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_ins;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  op_code;
  logic [1:0]  addr_mode;
  logic [2:0]  dst, src1, src2;
  logic [15:0] imm;
  logic        is_illegal;
  logic        is_halt;
  logic        halted;
`ifdef INSDEC_ILLEGAL_TRAP_EN
  logic        trap;
`endif
  logic        resume;

  int checks;
  int failures;

  insdec_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ins     (in_ins),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .op_code    (op_code),
    .addr_mode  (addr_mode),
    .dst        (dst),
    .src1       (src1),
    .src2       (src2),
    .imm        (imm),
    .is_illegal (is_illegal),
    .is_halt    (is_halt),
    .halted     (halted),
`ifdef INSDEC_ILLEGAL_TRAP_EN
    .trap       (trap),
`endif
    .resume     (resume)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_ins    = 16'h0A5F;
    out_ready = 1'b0;
    resume    = 1'b0;

    // Reset held for 3 clocks with in_valid asserted
    repeat (3) step();
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_imm", 32'(imm), 0);
    check_eq("rst_halted", 32'(halted), 0);
    check_eq("rst_in_ready", 32'(in_ready), 0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step();
    check_eq("post_rst_in_ready", 32'(in_ready), 1);
    check_eq("post_rst_out_valid", 32'(out_valid), 0);

    // Streaming with out_ready high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ins    = 16'h0A5F;
    step();
    check_eq("s0_valid", 32'(out_valid), 1);
    check_eq("s0_op", 32'(op_code), 1);
    check_eq("s0_am", 32'(addr_mode), 1);
    check_eq("s0_dst", 32'(dst), 1);
    check_eq("s0_src1", 32'(src1), 3);
    check_eq("s0_src2", 32'(src2), 7);
    check_eq("s0_imm", 32'(imm), 32'h001F);
    in_ins = 16'h1234;
    step();
    check_eq("s1_valid", 32'(out_valid), 1);
    check_eq("s1_op", 32'(op_code), 2);
    check_eq("s1_imm", 32'(imm), 32'hFFF4);
    in_ins = 16'h1AB8;
    step();
    check_eq("s2_op", 32'(op_code), 3);
    check_eq("s2_imm_sx", 32'(imm), 32'hFFF8);
    in_ins = 16'h1CB8;
    step();
    check_eq("s3_am", 32'(addr_mode), 2);
    check_eq("s3_imm_zx", 32'(imm), 32'h0038);
    in_valid = 1'b0;
    step();
    check_eq("s_drain_valid", 32'(out_valid), 0);

    // Backpressure: three offered, two accepted
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ins    = 16'h2053;
    step();
    in_ins = 16'h3053;
    step();
    check_eq("bp_full_ready", 32'(in_ready), 0);
    check_eq("bp_head_op", 32'(op_code), 4);
    in_ins = 16'h3853;
    step();
    check_eq("bp_still_full", 32'(in_ready), 0);
    step();
    check_eq("bp_stable_valid", 32'(out_valid), 1);
    check_eq("bp_stable_op", 32'(op_code), 4);
    out_ready = 1'b1;
    step();
    check_eq("bp_second_op", 32'(op_code), 6);
    check_eq("bp_ready_back", 32'(in_ready), 1);
    step();
    check_eq("bp_third_op", 32'(op_code), 7);
    check_eq("bp_third_valid", 32'(out_valid), 1);
    in_valid = 1'b0;
    step();
    check_eq("bp_drained", 32'(out_valid), 0);

    // HALT then op=2
    in_valid = 1'b1;
    in_ins   = 16'hF800;
    step();
    check_eq("h_is_halt", 32'(is_halt), 1);
    check_eq("h_valid", 32'(out_valid), 1);
    check_eq("h_blocked", 32'(in_ready), 0);
    check_eq("h_not_yet", 32'(halted), 0);
    in_ins = 16'h1000;
    step();
    check_eq("h_halted", 32'(halted), 1);
    check_eq("h_out_empty", 32'(out_valid), 0);
    check_eq("h_in_ready", 32'(in_ready), 0);
    step();
    check_eq("h_hold_halted", 32'(halted), 1);
    check_eq("h_hold_empty", 32'(out_valid), 0);
    resume = 1'b1;
    step();
    resume = 1'b0;
    check_eq("h_resumed", 32'(halted), 0);
    check_eq("h_ready_again", 32'(in_ready), 1);
    step();
    check_eq("h_op2_valid", 32'(out_valid), 1);
    check_eq("h_op2_op", 32'(op_code), 2);
    check_eq("h_op2_not_halt", 32'(is_halt), 0);
    in_valid = 1'b0;
    step();

    // Illegal opcode 0x15
    in_valid = 1'b1;
    in_ins   = 16'hA800;
    step();
    in_valid = 1'b0;
    check_eq("ill_flag", 32'(is_illegal), 1);
    check_eq("ill_not_halt", 32'(is_halt), 0);
    check_eq("ill_op", 32'(op_code), 32'h15);
    step();
    check_eq("ill_drained", 32'(out_valid), 0);
`ifdef INSDEC_ILLEGAL_TRAP_EN
    check_eq("trap_set", 32'(trap), 1);
    check_eq("trap_blocked", 32'(in_ready), 0);
    resume = 1'b1;
    step();
    resume = 1'b0;
    check_eq("trap_clear", 32'(trap), 0);
    check_eq("trap_ready", 32'(in_ready), 1);
`else
    check_eq("ill_ready", 32'(in_ready), 1);
    check_eq("ill_no_halt", 32'(halted), 0);
`endif

    // Reset with output and skid occupied
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ins    = 16'h2053;
    step();
    in_ins = 16'h3053;
    step();
    check_eq("mr_full", 32'(in_ready), 0);
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    check_eq("mr_rst_valid", 32'(out_valid), 0);
    check_eq("mr_rst_op", 32'(op_code), 0);
    step();
    check_eq("mr_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    step();
    check_eq("mr_no_stale", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
